// File: rtl/axis_sm_fifo.sv
// axis_sm_fifo
//   Stream buffer placed after the AXIS master mux. Upstream beats (a_sm_*) are stored in a
//   pDEPTH-entry first-word-fall-through FIFO and re-driven as f_sm_* to the IO-side consumer.
//   Downstream backpressure is therefore absorbed for up to pDEPTH beats before the mux stalls.
//
//   Optional feature: define AXIS_SM_FIFO_PKT_MODE_EN for packet mode. In packet mode the
//   output is held off until a complete packet (a tlast beat) is stored, or until the FIFO
//   is full.
//
// Ports
//   ASCLK, ARESET           clock (rising edge) and synchronous active-high reset
//   a_sm_t*                 upstream stream in; a_sm_tready = !fifo_full
//   f_sm_t*                 downstream stream out (head of FIFO)
//   fifo_flush              synchronous flush, beats priority over push/pop
//   fifo_level/full/empty   registered occupancy after this cycle's push/pop
module axis_sm_fifo #(
   parameter int unsigned pDATA_WIDTH = 32,
   parameter int unsigned pDEPTH      = 8,
   parameter int unsigned pLVL_W      = 4
) (
   input  logic                   ASCLK,
   input  logic                   ARESET,
   input  logic                   a_sm_tvalid,
   input  logic [pDATA_WIDTH-1:0] a_sm_tdata,
   input  logic [2:0]             a_sm_tid,
   input  logic                   a_sm_tkeep,
   input  logic                   a_sm_tlast,
   input  logic [3:0]             a_sm_tstrb,
   output logic                   a_sm_tready,
   output logic                   f_sm_tvalid,
   output logic [pDATA_WIDTH-1:0] f_sm_tdata,
   output logic [2:0]             f_sm_tid,
   output logic                   f_sm_tkeep,
   output logic                   f_sm_tlast,
   output logic [3:0]             f_sm_tstrb,
   input  logic                   f_sm_tready,
   input  logic                   fifo_flush,
   output logic [pLVL_W-1:0]      fifo_level,
   output logic                   fifo_full,
   output logic                   fifo_empty
);

   localparam int unsigned AW = pLVL_W - 1;
   localparam int unsigned EW = pDATA_WIDTH + 9;
   localparam logic [pLVL_W-1:0] FullLvl = pLVL_W'(pDEPTH);
   localparam logic [pLVL_W-1:0] One     = pLVL_W'(1);

   logic [EW-1:0]     mem_q [pDEPTH];
   logic [pLVL_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [pLVL_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [pLVL_W-1:0] level_q, level_d;
   logic              full_q, empty_q;
   logic              push, pop;
   logic [EW-1:0]     wr_entry, head;

   assign wr_entry = {a_sm_tdata, a_sm_tid, a_sm_tkeep, a_sm_tlast, a_sm_tstrb};
   assign head     = mem_q[rd_ptr_q[AW-1:0]];

   assign {f_sm_tdata, f_sm_tid, f_sm_tkeep, f_sm_tlast, f_sm_tstrb} = head;

   assign a_sm_tready = ~full_q;
   assign fifo_level  = level_q;
   assign fifo_full   = full_q;
   assign fifo_empty  = empty_q;

   // No pass-through when full: tready comes from the registered full flag only.
   assign push = a_sm_tvalid & ~full_q;
   assign pop  = f_sm_tvalid & f_sm_tready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + One;
      if (pop)  rd_ptr_d = rd_ptr_q + One;
      // Pointers carry one extra bit, so the modular difference is the occupancy.
      level_d = wr_ptr_d - rd_ptr_d;
   end

`ifdef AXIS_SM_FIFO_PKT_MODE_EN
   logic [pLVL_W-1:0] pkt_cnt_q, pkt_cnt_d;
   logic              push_last, pop_last;

   assign push_last = push & a_sm_tlast;
   assign pop_last  = pop & f_sm_tlast;

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (push_last & ~pop_last)      pkt_cnt_d = pkt_cnt_q + One;
      else if (pop_last & ~push_last) pkt_cnt_d = pkt_cnt_q - One;
   end

   // Full override: a packet longer than the FIFO must still drain or nothing moves.
   assign f_sm_tvalid = ~empty_q & ((pkt_cnt_q != '0) | full_q);

   always_ff @(posedge ASCLK) begin
      if (ARESET || fifo_flush) begin
         pkt_cnt_q <= '0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
      end
   end
`else
   assign f_sm_tvalid = ~empty_q;
`endif

   always_ff @(posedge ASCLK) begin
      if (ARESET) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else if (fifo_flush) begin
         // Stored payload is left in place; it is unreachable once the pointers are cleared.
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= (level_d == FullLvl);
         empty_q  <= (level_d == '0);
      end
   end

endmodule

// File: tb/tb_axis_sm_fifo.sv
module tb_axis_sm_fifo;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned LW    = 4;
`ifdef AXIS_SM_FIFO_PKT_MODE_EN
   localparam bit PktMode = 1'b1;
`else
   localparam bit PktMode = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          ARESET;
   logic          a_sm_tvalid;
   logic [DW-1:0] a_sm_tdata;
   logic [2:0]    a_sm_tid;
   logic          a_sm_tkeep;
   logic          a_sm_tlast;
   logic [3:0]    a_sm_tstrb;
   logic          a_sm_tready;
   logic          f_sm_tvalid;
   logic [DW-1:0] f_sm_tdata;
   logic [2:0]    f_sm_tid;
   logic          f_sm_tkeep;
   logic          f_sm_tlast;
   logic [3:0]    f_sm_tstrb;
   logic          f_sm_tready;
   logic          fifo_flush;
   logic [LW-1:0] fifo_level;
   logic          fifo_full;
   logic          fifo_empty;

   always #5 clk = ~clk;

   axis_sm_fifo #(
      .pDATA_WIDTH(DW),
      .pDEPTH     (DEPTH),
      .pLVL_W     (LW)
   ) dut (
      .ASCLK      (clk),
      .ARESET     (ARESET),
      .a_sm_tvalid(a_sm_tvalid),
      .a_sm_tdata (a_sm_tdata),
      .a_sm_tid   (a_sm_tid),
      .a_sm_tkeep (a_sm_tkeep),
      .a_sm_tlast (a_sm_tlast),
      .a_sm_tstrb (a_sm_tstrb),
      .a_sm_tready(a_sm_tready),
      .f_sm_tvalid(f_sm_tvalid),
      .f_sm_tdata (f_sm_tdata),
      .f_sm_tid   (f_sm_tid),
      .f_sm_tkeep (f_sm_tkeep),
      .f_sm_tlast (f_sm_tlast),
      .f_sm_tstrb (f_sm_tstrb),
      .f_sm_tready(f_sm_tready),
      .fifo_flush (fifo_flush),
      .fifo_level (fifo_level),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: contents as a plain queue of {tdata,tid,tkeep,tlast,tstrb}.
   logic [40:0]   model_q[$];
   logic [DW-1:0] obs_q[$];    // tdata of every beat the DUT handed downstream
   bit            last_push;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input logic [DW-1:0] d, input logic [2:0] id,
                        input bit last, input bit rdy, input bit fl);
      a_sm_tvalid = v;
      a_sm_tdata  = d;
      a_sm_tid    = id;
      a_sm_tkeep  = 1'b1;
      a_sm_tlast  = last;
      a_sm_tstrb  = 4'hF;
      f_sm_tready = rdy;
      fifo_flush  = fl;
   endtask

   // Called just after a falling edge with inputs applied: compare outputs against the model,
   // advance one clock, update the model, return at the next falling edge.
   task automatic cycle();
      int          n_last;
      bit          exp_ready, exp_valid, push, pop;
      logic [40:0] entry;
      n_last = 0;
      foreach (model_q[k]) if (model_q[k][4]) n_last++;
      exp_ready = (model_q.size() != DEPTH);
      exp_valid = (model_q.size() != 0) &&
                  (!PktMode || n_last > 0 || model_q.size() == DEPTH);
      check("a_sm_tready", 64'(a_sm_tready), 64'(exp_ready));
      check("f_sm_tvalid", 64'(f_sm_tvalid), 64'(exp_valid));
      check("fifo_level",  64'(fifo_level),  64'(model_q.size()));
      check("fifo_full",   64'(fifo_full),   64'(model_q.size() == DEPTH));
      check("fifo_empty",  64'(fifo_empty),  64'(model_q.size() == 0));
      if (exp_valid)
         check("f_sm_payload",
               64'({f_sm_tdata, f_sm_tid, f_sm_tkeep, f_sm_tlast, f_sm_tstrb}),
               64'(model_q[0]));
      entry = {a_sm_tdata, a_sm_tid, a_sm_tkeep, a_sm_tlast, a_sm_tstrb};
      push  = a_sm_tvalid && exp_ready;
      pop   = exp_valid && f_sm_tready;
      if (pop && !ARESET && !fifo_flush) obs_q.push_back(f_sm_tdata);
      @(posedge clk);
      if (ARESET || fifo_flush) begin
         model_q.delete();
         push = 1'b0;
      end else begin
         if (pop) void'(model_q.pop_front());
         if (push) model_q.push_back(entry);
      end
      last_push = push;
      @(negedge clk);
   endtask

   task automatic flush_cycle();
      drive(0, '0, 3'd0, 0, 0, 1);
      cycle();
      fifo_flush = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset
      ARESET = 1'b1;
      drive(0, '0, 3'd0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      ARESET = 1'b0;
      model_q.delete();
      check("rst_tready", 64'(a_sm_tready), 64'd1);
      check("rst_tvalid", 64'(f_sm_tvalid), 64'd0);
      check("rst_level",  64'(fifo_level),  64'd0);
      check("rst_empty",  64'(fifo_empty),  64'd1);
      check("rst_full",   64'(fifo_full),   64'd0);
      check("rst_tdata",  64'(f_sm_tdata),  64'd0);

      // 2: one-cycle latency
      drive(1, 32'hA5A5_0001, 3'd2, 1, 1, 0);
      cycle();
      drive(0, '0, 3'd0, 0, 1, 0);
      check("lat_valid", 64'(f_sm_tvalid), 64'd1);
      check("lat_data",  64'(f_sm_tdata),  64'hA5A5_0001);
      check("lat_tid",   64'(f_sm_tid),    64'd2);
      check("lat_level1", 64'(fifo_level), 64'd1);
      cycle();
      check("lat_level0", 64'(fifo_level), 64'd0);

      // 3: fill and backpressure
      flush_cycle();
      obs_q.delete();
      for (int i = 0; i < 8; i++) begin
         drive(1, DW'(i), 3'd1, 1, 0, 0);
         cycle();
      end
      check("fill_full",  64'(fifo_full),   64'd1);
      check("fill_ready", 64'(a_sm_tready), 64'd0);
      drive(1, 32'd8, 3'd1, 1, 0, 0);
      cycle();
      check("fill_held_level", 64'(fifo_level), 64'd8);
      f_sm_tready = 1'b1;
      last_push = 1'b0;
      for (int i = 0; i < 20 && !last_push; i++) cycle();
      check("fill_9th_taken", 64'(last_push), 64'd1);
      a_sm_tvalid = 1'b0;
      repeat (12) cycle();
      check("fill_out_count", 64'(obs_q.size()), 64'd9);
      for (int i = 0; i < 9 && i < obs_q.size(); i++)
         check($sformatf("fill_out[%0d]", i), 64'(obs_q[i]), 64'(i));

      // 4: concurrent push/pop at level 4
      flush_cycle();
      obs_q.delete();
      for (int i = 0; i < 4; i++) begin
         drive(1, DW'(100 + i), 3'd3, 1, 0, 0);
         cycle();
      end
      for (int i = 0; i < 20; i++) begin
         drive(1, DW'(200 + i), 3'd3, 1, 1, 0);
         cycle();
         check("conc_level", 64'(fifo_level), 64'd4);
      end
      check("conc_out_count", 64'(obs_q.size()), 64'd20);
      for (int i = 0; i < 20 && i < obs_q.size(); i++)
         check($sformatf("conc_out[%0d]", i), 64'(obs_q[i]),
               (i < 4) ? 64'(100 + i) : 64'(200 + i - 4));

      // 5: flush mid-packet with a concurrent push
      flush_cycle();
      for (int i = 0; i < 3; i++) begin
         drive(1, DW'(300 + i), 3'd4, 0, 0, 0);
         cycle();
      end
      obs_q.delete();
      drive(1, 32'hDEAD_BEEF, 3'd4, 1, 0, 1);
      cycle();
      check("flush_level", 64'(fifo_level),  64'd0);
      check("flush_valid", 64'(f_sm_tvalid), 64'd0);
      check("flush_ready", 64'(a_sm_tready), 64'd1);
      drive(0, '0, 3'd0, 0, 1, 0);
      repeat (3) cycle();
      check("flush_no_out", 64'(obs_q.size()), 64'd0);

      // Reset mid-packet behaves like a flush
      for (int i = 0; i < 2; i++) begin
         drive(1, DW'(400 + i), 3'd5, 0, 0, 0);
         cycle();
      end
      ARESET = 1'b1;
      drive(1, 32'h1234_5678, 3'd5, 0, 0, 0);
      cycle();
      ARESET = 1'b0;
      check("mrst_level", 64'(fifo_level), 64'd0);
      check("mrst_tdata", 64'(f_sm_tdata), 64'd0);

`ifdef AXIS_SM_FIFO_PKT_MODE_EN
      // 6: packet mode
      flush_cycle();
      for (int i = 0; i < 3; i++) begin
         drive(1, DW'(500 + i), 3'd6, 0, 0, 0);
         cycle();
      end
      check("pkt_partial_valid", 64'(f_sm_tvalid), 64'd0);
      drive(1, 32'd503, 3'd6, 1, 0, 0);
      cycle();
      check("pkt_complete_valid", 64'(f_sm_tvalid), 64'd1);
      flush_cycle();
      for (int i = 0; i < 8; i++) begin
         drive(1, DW'(600 + i), 3'd6, 0, 0, 0);
         cycle();
      end
      check("pkt_full_override", 64'(f_sm_tvalid), 64'd1);
`endif

      // Randomized traffic against the model
      flush_cycle();
      for (int i = 0; i < 400; i++) begin
         a_sm_tvalid = ($urandom_range(3) != 0);
         a_sm_tdata  = $urandom;
         a_sm_tid    = 3'($urandom_range(7));
         a_sm_tkeep  = 1'($urandom_range(1));
         a_sm_tlast  = ($urandom_range(3) == 0);
         a_sm_tstrb  = 4'($urandom_range(15));
         f_sm_tready = ($urandom_range(2) != 0);
         fifo_flush  = ($urandom_range(63) == 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
